// File: rtl/request_unit_rr_pkg.sv
// rtl/request_unit_rr_pkg.sv - shared types and helpers for the round-robin request unit
package request_unit_rr_pkg;

  typedef enum logic [1:0] {
    RU_FETCH  = 2'd0,
    RU_DATA   = 2'd1,
    RU_HALTED = 2'd2
  } ru_state_t;

  // Width of a channel index; a single channel still needs one bit of select.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/request_unit_rr_if.sv
// rtl/request_unit_rr_if.sv - control unit / arbiter handshake bundle for the request unit
interface request_unit_rr_if
  import request_unit_rr_pkg::*;
#(
  parameter int NDCH = 2
);
  localparam int DSEL_W = sel_width(NDCH);

  logic              cuIRE;
  logic [NDCH-1:0]   cuDRE;
  logic [NDCH-1:0]   cuDWE;
  logic              cuHALT;
  logic              ihit;
  logic              dhit;
  logic              iREN;
  logic              dREN;
  logic              dWEN;
  logic [DSEL_W-1:0] dsel;
  logic              pcWEN;
  logic              halted;
  logic              timeout_err;

  modport ru (
    input  cuIRE, cuDRE, cuDWE, cuHALT, ihit, dhit,
    output iREN, dREN, dWEN, dsel, pcWEN, halted, timeout_err
  );

  modport tb (
    output cuIRE, cuDRE, cuDWE, cuHALT, ihit, dhit,
    input  iREN, dREN, dWEN, dsel, pcWEN, halted, timeout_err
  );

endinterface

// File: rtl/request_unit_rr_pick.sv
// rtl/request_unit_rr_pick.sv - combinational round-robin picker: first pending channel at or after ptr
module rr_pick
  import request_unit_rr_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]            pend,
  input  logic [sel_width(N)-1:0] ptr,
  output logic [sel_width(N)-1:0] grant,
  output logic                    any
);
  localparam int W = sel_width(N);

  int           j;
  logic [W-1:0] idx;

  // Scan offsets from the far end back toward ptr so the closest pending channel wins last.
  always_comb begin
    grant = '0;
    any   = 1'b0;
    j     = 0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      idx = W'(j);
      if (pend[idx]) begin
        grant = idx;
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/request_unit_rr.sv
// rtl/request_unit_rr.sv - multi-channel request unit: serves per-instruction data requests round-robin
module request_unit_rr
  import request_unit_rr_pkg::*;
#(
  parameter int NDCH    = 2,
  parameter int TMO_W   = 8,
  parameter int TIMEOUT = 200
) (
  input logic        CLK,
  input logic        nRST,
  request_unit_rr_if.ru ruif
);
  localparam int                DSEL_W   = sel_width(NDCH);
  localparam logic [TMO_W-1:0]  TMO_LAST = (TIMEOUT > 0) ? TMO_W'(TIMEOUT - 1) : '0;
  localparam logic [DSEL_W-1:0] LAST_CH  = DSEL_W'(NDCH - 1);

  ru_state_t         state, state_n;
  logic [NDCH-1:0]   pend, pend_n;
  logic [NDCH-1:0]   wr, wr_n;
  logic [DSEL_W-1:0] ptr, ptr_n;
  logic [TMO_W-1:0]  tmo, tmo_n;
  logic              halt_pend, halt_pend_n;
  logic              terr, terr_n;

  logic [DSEL_W-1:0] grant;
  logic              any;
  logic              tmo_hit;
  logic              done;

  logic              i_ren, d_ren, d_wen, pc_wen;
  logic [DSEL_W-1:0] dsel_c;

  rr_pick #(.N(NDCH)) u_pick (
    .pend  (pend),
    .ptr   (ptr),
    .grant (grant),
    .any   (any)
  );

  // State and per-instruction bookkeeping; reset drops any in-flight access.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= RU_FETCH;
      pend      <= '0;
      wr        <= '0;
      ptr       <= '0;
      tmo       <= '0;
      halt_pend <= 1'b0;
      terr      <= 1'b0;
    end else begin
      state     <= state_n;
      pend      <= pend_n;
      wr        <= wr_n;
      ptr       <= ptr_n;
      tmo       <= tmo_n;
      halt_pend <= halt_pend_n;
      terr      <= terr_n;
    end
  end

  // Next-state and output decode; a timeout retires the access exactly like a dhit.
  always_comb begin
    state_n     = state;
    pend_n      = pend;
    wr_n        = wr;
    ptr_n       = ptr;
    tmo_n       = tmo;
    halt_pend_n = halt_pend;
    terr_n      = terr;
    i_ren       = 1'b0;
    d_ren       = 1'b0;
    d_wen       = 1'b0;
    pc_wen      = 1'b0;
    dsel_c      = '0;
    tmo_hit     = 1'b0;
    done        = 1'b0;

    case (state)
      RU_FETCH: begin
        i_ren = ruif.cuIRE;
        if (ruif.ihit) begin
          pend_n      = ruif.cuDRE | ruif.cuDWE;
          wr_n        = ruif.cuDWE;
          halt_pend_n = ruif.cuHALT;
          if ((ruif.cuDRE | ruif.cuDWE) == '0) begin
            pc_wen  = 1'b1;
            state_n = ruif.cuHALT ? RU_HALTED : RU_FETCH;
          end else begin
            state_n = RU_DATA;
          end
        end
      end

      RU_DATA: begin
        if (any) begin
          dsel_c  = grant;
          d_wen   = wr[grant];
          d_ren   = ~wr[grant];
          tmo_hit = (TIMEOUT != 0) && (tmo == TMO_LAST) && !ruif.dhit;
          done    = ruif.dhit | tmo_hit;
          if (done) begin
            pend_n[grant] = 1'b0;
            ptr_n         = (grant == LAST_CH) ? '0 : grant + DSEL_W'(1);
            tmo_n         = '0;
            if (tmo_hit) terr_n = 1'b1;
            if (pend_n == '0) begin
              pc_wen  = 1'b1;
              state_n = halt_pend ? RU_HALTED : RU_FETCH;
            end
          end else begin
            tmo_n = tmo + TMO_W'(1);
          end
        end else begin
          state_n = RU_FETCH;
        end
      end

      RU_HALTED: begin
        state_n = RU_HALTED;
      end

      default: begin
        state_n = RU_FETCH;
      end
    endcase
  end

  assign ruif.iREN        = i_ren;
  assign ruif.dREN        = d_ren;
  assign ruif.dWEN        = d_wen;
  assign ruif.dsel        = dsel_c;
  assign ruif.pcWEN       = pc_wen & nRST;
  assign ruif.halted      = (state == RU_HALTED);
  assign ruif.timeout_err = terr;

endmodule

// File: tb/tb_request_unit_rr.sv
// tb/tb_request_unit_rr.sv - scoreboard bench for request_unit_rr with two channels and timeout 8
module tb_request_unit_rr;
  import request_unit_rr_pkg::*;

  localparam int NDCH = 2;
  localparam int TMO  = 8;

  logic CLK = 1'b0;
  logic nRST;

  request_unit_rr_if #(.NDCH(NDCH)) ruif ();

  request_unit_rr #(.NDCH(NDCH), .TMO_W(8), .TIMEOUT(TMO)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .ruif (ruif)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic ch;
    logic wr;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic m_ptr   = 1'b0;
  logic exp_terr = 1'b0;

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  // One instruction: ihit with the given requests, then each queued access retired after its delay.
  task automatic run_instr(input logic [1:0] dre, input logic [1:0] dwe, input logic halt,
                           input int d_first, input int d_second);
    logic [1:0] pend;
    logic       c;
    exp_t       e;
    int         served;
    int         dly;
    logic       last;
    logic       done;
    tick();
    ruif.cuIRE = 1'b1; ruif.ihit = 1'b1;
    ruif.cuDRE = dre;  ruif.cuDWE = dwe; ruif.cuHALT = halt;
    pend = dre | dwe;
    for (int i = 0; i < 2; i++) begin
      c = (i == 0) ? m_ptr : ~m_ptr;
      if (pend[c]) begin
        e.ch = c;
        e.wr = dwe[c];
        sb.push_back(e);
      end
    end
    #1;
    n_tests++; if (ruif.pcWEN !== (pend == 2'b00)) begin n_fail++; $display("FAIL ihit_pcwen: got %b expected %b", ruif.pcWEN, (pend == 2'b00)); end
    n_tests++; if (ruif.iREN !== 1'b1) begin n_fail++; $display("FAIL ihit_iren: got %b expected 1", ruif.iREN); end
    tick();
    ruif.ihit = 1'b0; ruif.cuDRE = '0; ruif.cuDWE = '0; ruif.cuHALT = 1'b0;
    served = 0;
    while (sb.size() > 0) begin
      e    = sb[0];
      dly  = (served == 0) ? d_first : d_second;
      done = 1'b0;
      for (int k = 0; k < TMO + 4 && !done; k++) begin
        ruif.dhit = (k == dly);
        #1;
        n_tests++; if (ruif.dREN !== ~e.wr) begin n_fail++; $display("FAIL data_dren: got %b expected %b (k=%0d)", ruif.dREN, ~e.wr, k); end
        n_tests++; if (ruif.dWEN !== e.wr) begin n_fail++; $display("FAIL data_dwen: got %b expected %b (k=%0d)", ruif.dWEN, e.wr, k); end
        n_tests++; if (ruif.dsel !== e.ch) begin n_fail++; $display("FAIL data_dsel: got %b expected %b (k=%0d)", ruif.dsel, e.ch, k); end
        n_tests++; if (ruif.iREN !== 1'b0 || ruif.halted !== 1'b0) begin n_fail++; $display("FAIL data_iren_halted: got %b%b expected 00", ruif.iREN, ruif.halted); end
        done = (k == dly) || (k == TMO - 1);
        last = done && (sb.size() == 1);
        n_tests++; if (ruif.pcWEN !== last) begin n_fail++; $display("FAIL data_pcwen: got %b expected %b (k=%0d)", ruif.pcWEN, last, k); end
        if (done) begin
          if (k != dly) exp_terr = 1'b1;
          m_ptr = ~e.ch;
          void'(sb.pop_front());
          served++;
        end
        tick();
        ruif.dhit = 1'b0;
      end
      if (!done) begin
        n_tests++; n_fail++;
        $display("FAIL access_bound: got no retire expected retire within %0d cycles", TMO + 4);
        sb.delete();
      end
    end
    #1;
    n_tests++; if (ruif.timeout_err !== exp_terr) begin n_fail++; $display("FAIL post_terr: got %b expected %b", ruif.timeout_err, exp_terr); end
    n_tests++; if (ruif.halted !== halt) begin n_fail++; $display("FAIL post_halted: got %b expected %b", ruif.halted, halt); end
    n_tests++; if (ruif.iREN !== ~halt) begin n_fail++; $display("FAIL post_iren: got %b expected %b", ruif.iREN, ~halt); end
    n_tests++; if (ruif.dREN !== 1'b0 || ruif.dWEN !== 1'b0 || ruif.pcWEN !== 1'b0) begin n_fail++; $display("FAIL post_idle: got %b%b%b expected 000", ruif.dREN, ruif.dWEN, ruif.pcWEN); end
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    ruif.cuIRE = 1'b1; ruif.cuDRE = '0; ruif.cuDWE = '0;
    ruif.cuHALT = 1'b0; ruif.ihit = 1'b0; ruif.dhit = 1'b0;
    #3;
    n_tests++; if (ruif.iREN !== 1'b1) begin n_fail++; $display("FAIL reset_iren: got %b expected 1", ruif.iREN); end
    n_tests++; if ({ruif.dREN, ruif.dWEN, ruif.pcWEN, ruif.halted, ruif.timeout_err} !== 5'b0) begin n_fail++; $display("FAIL reset_outs: got %b expected 00000", {ruif.dREN, ruif.dWEN, ruif.pcWEN, ruif.halted, ruif.timeout_err}); end
    n_tests++; if (ruif.dsel !== 1'b0) begin n_fail++; $display("FAIL reset_dsel: got %b expected 0", ruif.dsel); end
    tick();
    nRST = 1'b1;
  endtask

  task automatic test_no_data();
    run_instr(2'b00, 2'b00, 1'b0, 0, 0);
  endtask

  task automatic test_both_channels();
    run_instr(2'b01, 2'b10, 1'b0, 1, 2);
    run_instr(2'b11, 2'b00, 1'b0, 0, 0);
    run_instr(2'b11, 2'b01, 1'b0, 0, 1);
  endtask

  task automatic test_round_robin();
    run_instr(2'b01, 2'b00, 1'b0, 0, 0);
    run_instr(2'b11, 2'b00, 1'b0, 2, 1);
    run_instr(2'b10, 2'b00, 1'b0, 3, 0);
    run_instr(2'b00, 2'b11, 1'b0, 0, 0);
  endtask

  task automatic test_timeout();
    run_instr(2'b01, 2'b00, 1'b0, TMO - 1, 0);
    run_instr(2'b00, 2'b10, 1'b0, 50, 0);
  endtask

  task automatic test_reset_mid_access();
    tick();
    ruif.ihit = 1'b1; ruif.cuDRE = 2'b01; ruif.cuDWE = 2'b00;
    tick();
    ruif.ihit = 1'b0; ruif.cuDRE = 2'b00;
    #1;
    n_tests++; if (ruif.dREN !== 1'b1) begin n_fail++; $display("FAIL mid_pre_dren: got %b expected 1", ruif.dREN); end
    tick();
    #1;
    ruif.dhit = 1'b1; ruif.ihit = 1'b1;
    nRST = 1'b0;
    #1;
    n_tests++; if ({ruif.dREN, ruif.dWEN, ruif.pcWEN, ruif.halted, ruif.timeout_err} !== 5'b0) begin n_fail++; $display("FAIL mid_reset_outs: got %b expected 00000", {ruif.dREN, ruif.dWEN, ruif.pcWEN, ruif.halted, ruif.timeout_err}); end
    ruif.dhit = 1'b0; ruif.ihit = 1'b0;
    m_ptr = 1'b0; exp_terr = 1'b0;
    tick();
    nRST = 1'b1;
    #1;
    n_tests++; if (ruif.iREN !== 1'b1 || ruif.dREN !== 1'b0) begin n_fail++; $display("FAIL mid_release_fetch: got %b%b expected 10", ruif.iREN, ruif.dREN); end
    run_instr(2'b11, 2'b00, 1'b0, 0, 3);
  endtask

  task automatic test_halt_drain();
    run_instr(2'b00, 2'b01, 1'b1, 2, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      ruif.ihit = 1'b1; ruif.cuDRE = 2'b11; ruif.dhit = 1'b1;
      #1;
      n_tests++; if ({ruif.iREN, ruif.dREN, ruif.dWEN, ruif.pcWEN, ruif.halted} !== 5'b00001) begin n_fail++; $display("FAIL halted_ignore: got %b expected 00001", {ruif.iREN, ruif.dREN, ruif.dWEN, ruif.pcWEN, ruif.halted}); end
    end
    ruif.ihit = 1'b0; ruif.cuDRE = 2'b00; ruif.dhit = 1'b0;
    tick();
    nRST = 1'b0;
    #1;
    n_tests++; if (ruif.halted !== 1'b0 || ruif.iREN !== 1'b1) begin n_fail++; $display("FAIL halt_reset: got halted=%b iREN=%b expected 0 1", ruif.halted, ruif.iREN); end
  endtask

  initial begin
    test_reset();
    test_no_data();
    test_both_channels();
    test_round_robin();
    test_timeout();
    test_reset_mid_access();
    test_halt_drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
